alu_pipe: RTL and testbench

Parametrised, handshaked ALU that succeeds the single-cycle combinational datapath ALU. It adds an internal NZCV flag register with conditional update, which feeds carry-in to ADC, and valid/ready flow control on both sides. It supports eight operations, including shifts and an optional iterative multiplier. It sits between the decode/operand-fetch stage and writeback in the datapath.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_mul_iter.sv | 58 +++++
 rtl/alu_pipe.sv | 183 ++++++++++++++++++
 tb/tb_alu_pipe.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM state and flag types shared by alu_pipe
package alu_pkg;

    localparam logic [2:0] OP_ADC = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_ROR = 3'b011;
    localparam logic [2:0] OP_ORR = 3'b100;
    localparam logic [2:0] OP_EOR = 3'b101;
    localparam logic [2:0] OP_LSL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {
        ST_IDLE,
        ST_MULT
    } state_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative shift-add unsigned multiplier, one bit per cycle
module alu_mul_iter #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             ack_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] prod_o
);

    localparam logic [SHW:0] CNT_DONE = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

    logic [SHW:0]     cnt_q;
    logic             run_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;

    // Done holds (counter frozen) until the owner can take the product
    assign done_o = run_q && (cnt_q == CNT_DONE);
    assign busy_o = run_q && (cnt_q != CNT_DONE);
    assign prod_o = acc_q;

    // Load operands on start, then add the shifted multiplicand for each set multiplier bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            run_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else if (start_i) begin
            cnt_q    <= '0;
            run_q    <= 1'b1;
            mcand_q  <= a_i;
            mplier_q <= b_i;
            acc_q    <= '0;
        end else if (busy_o) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_ONE;
        end else if (done_o && ack_i) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked ALU with NZCV flag register; ALU_MUL_EN enables iterative MUL on opcode 111
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] aluIn1,
    input  logic [WIDTH-1:0] aluIn2,
    input  logic [2:0]       aluOp,
    input  logic             setFlags,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] aluOut,
    output logic             N,
    output logic             Z,
    output logic             C,
    output logic             V,
    output logic             busy
);

    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

    logic [WIDTH-1:0] aluOut_q;
    logic             outValid_q;
    flags_t           flags_q;
    logic [WIDTH-1:0] res_d;
    flags_t           flags_d;
    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   sub_w;
    logic [WIDTH:0]   lsl_w;
    logic [WIDTH-1:0] ror_amt;
    logic             out_free;
    logic             accept;

    assign out_free = !outValid_q || outReady;
    assign aluOut   = aluOut_q;
    assign outValid = outValid_q;
    assign {N, Z, C, V} = flags_q;

    // Single-cycle result and candidate flags from the operands and current flags
    always_comb begin
        add_w   = {1'b0, aluIn1} + {1'b0, aluIn2} + {{WIDTH{1'b0}}, flags_q.c};
        sub_w   = {1'b0, aluIn2} + {1'b0, ~aluIn1} + {{WIDTH{1'b0}}, 1'b1};
        lsl_w   = {1'b0, aluIn2} << aluIn1[SHW:0];
        ror_amt = {{(WIDTH-SHW){1'b0}}, aluIn1[SHW-1:0]};
        res_d   = aluIn2;
        flags_d = flags_q;
        case (aluOp)
            OP_ADC: begin
                res_d     = add_w[WIDTH-1:0];
                flags_d.c = add_w[WIDTH];
                flags_d.v = (aluIn1[WIDTH-1] == aluIn2[WIDTH-1]) && (res_d[WIDTH-1] != aluIn1[WIDTH-1]);
            end
            OP_SUB: begin
                res_d     = sub_w[WIDTH-1:0];
                flags_d.c = sub_w[WIDTH];
                flags_d.v = (aluIn1[WIDTH-1] != aluIn2[WIDTH-1]) && (res_d[WIDTH-1] != aluIn2[WIDTH-1]);
            end
            OP_AND: res_d = aluIn1 & aluIn2;
            OP_ROR: begin
                // A shift by WIDTH yields zero, so amount 0 leaves aluIn2 intact
                res_d = (aluIn2 >> ror_amt) | (aluIn2 << (WIDTH_V - ror_amt));
                if (aluIn1 != '0) begin
                    flags_d.c = res_d[WIDTH-1];
                end
            end
            OP_ORR: res_d = aluIn1 | aluIn2;
            OP_EOR: res_d = aluIn1 ^ aluIn2;
            OP_LSL: begin
                if (aluIn1 == '0) begin
                    res_d = aluIn2;
                end else if (aluIn1 > WIDTH_V) begin
                    res_d     = '0;
                    flags_d.c = 1'b0;
                end else begin
                    res_d     = lsl_w[WIDTH-1:0];
                    flags_d.c = lsl_w[WIDTH];
                end
            end
            default: res_d = aluIn2;
        endcase
        flags_d.n = res_d[WIDTH-1];
        flags_d.z = (res_d == '0);
    end

`ifdef ALU_MUL_EN
    state_e           state_q;
    logic             setf_q;
    logic             mul_start;
    logic             mul_ack;
    logic             mul_done;
    logic [WIDTH-1:0] mul_prod;

    assign inReady   = (state_q == ST_IDLE) && out_free;
    assign accept    = inValid && inReady;
    assign mul_start = accept && (aluOp == OP_MUL);
    assign mul_ack   = (state_q == ST_MULT) && mul_done && out_free;

    alu_mul_iter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (mul_start),
        .a_i     (aluIn1),
        .b_i     (aluIn2),
        .ack_i   (mul_ack),
        .busy_o  (busy),
        .done_o  (mul_done),
        .prod_o  (mul_prod)
    );

    // FSM plus output and flag registers; MUL completion writes N/Z only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            setf_q     <= 1'b0;
            aluOut_q   <= '0;
            outValid_q <= 1'b0;
            flags_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept && (aluOp == OP_MUL)) begin
                        state_q    <= ST_MULT;
                        setf_q     <= setFlags;
                        outValid_q <= 1'b0;
                    end else if (accept) begin
                        aluOut_q   <= res_d;
                        outValid_q <= 1'b1;
                        if (setFlags) begin
                            flags_q <= flags_d;
                        end
                    end else if (outReady) begin
                        outValid_q <= 1'b0;
                    end
                end
                ST_MULT: begin
                    if (mul_ack) begin
                        state_q    <= ST_IDLE;
                        aluOut_q   <= mul_prod;
                        outValid_q <= 1'b1;
                        if (setf_q) begin
                            flags_q.n <= mul_prod[WIDTH-1];
                            flags_q.z <= (mul_prod == '0);
                        end
                    end else if (outReady) begin
                        outValid_q <= 1'b0;
                    end
                end
            endcase
        end
    end
`else
    assign inReady = out_free;
    assign accept  = inValid && inReady;
    assign busy    = 1'b0;

    // Output and flag registers: load on accept, drop valid when popped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aluOut_q   <= '0;
            outValid_q <= 1'b0;
            flags_q    <= '0;
        end else if (accept) begin
            aluOut_q   <= res_d;
            outValid_q <= 1'b1;
            if (setFlags) begin
                flags_q <= flags_d;
            end
        end else if (outReady) begin
            outValid_q <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - scoreboard bench for alu_pipe
module tb_alu_pipe;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inValid;
    logic        inReady;
    logic [31:0] aluIn1;
    logic [31:0] aluIn2;
    logic [2:0]  aluOp;
    logic        setFlags;
    logic        outValid;
    logic        outReady;
    logic [31:0] aluOut;
    logic        N, Z, C, V;
    logic        busy;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [3:0]  nzcv;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        sf;
        logic [31:0] res;
        logic [3:0]  nzcv;
    } vec_t;

    exp_t sb_q[$];
    vec_t vec_q[$];
    int   tests = 0;
    int   fails = 0;
    int   k;
    int   busy_cnt;

    alu_pipe #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .inValid  (inValid),
        .inReady  (inReady),
        .aluIn1   (aluIn1),
        .aluIn2   (aluIn2),
        .aluOp    (aluOp),
        .setFlags (setFlags),
        .outValid (outValid),
        .outReady (outReady),
        .aluOut   (aluOut),
        .N        (N),
        .Z        (Z),
        .C        (C),
        .V        (V),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic sf, input logic [31:0] res, input logic [3:0] nzcv);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.sf = sf; v.res = res; v.nzcv = nzcv;
        vec_q.push_back(v);
    endtask

    // Present an op, wait (bounded) for inReady, queue its expectation, release after accept edge
    task automatic issue(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic sf, input logic [31:0] res,
                         input logic [3:0] nzcv, input bit push);
        exp_t e;
        int   n;
        n = 0;
        inValid = 1'b1; aluOp = op; aluIn1 = a; aluIn2 = b; setFlags = sf;
        forever begin
            @(negedge clk);
            if (inReady) break;
            n++;
            if (n > 200) break;
        end
        if (n > 200) begin
            chk({name, "_accept_timeout"}, 32'd0, 32'd1);
            inValid = 1'b0;
        end else begin
            if (push) begin
                e.name = name; e.res = res; e.nzcv = nzcv;
                sb_q.push_back(e);
            end
            @(posedge clk);
            #1;
            inValid = 1'b0;
        end
    endtask

    // Monitor: pop and compare on every output handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && outValid && outReady) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got %h expected none", aluOut);
                end else begin
                    e = sb_q.pop_front();
                    chk({e.name, "_res"}, aluOut, e.res);
                    chk({e.name, "_nzcv"}, {28'd0, N, Z, C, V}, {28'd0, e.nzcv});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; inValid = 1'b0; aluIn1 = '0; aluIn2 = '0; aluOp = '0;
        setFlags = 1'b0; outReady = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_aluout", aluOut, 32'd0);
        chk("rst_outvalid", {31'd0, outValid}, 32'd0);
        chk("rst_nzcv", {28'd0, N, Z, C, V}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_inready", {31'd0, inReady}, 32'd1);

        add_vec(OP_ADC, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0000, 4'b0110);
        add_vec(OP_ADC, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 4'b0000);
        add_vec(OP_SUB, 32'h0000_0001, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 4'b1000);
        add_vec(OP_SUB, 32'h0000_0001, 32'h8000_0000, 1'b1, 32'h7FFF_FFFF, 4'b0011);
        add_vec(OP_ROR, 32'h0000_0004, 32'h0000_000F, 1'b1, 32'hF000_0000, 4'b1011);
        add_vec(OP_LSL, 32'h0000_0021, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 4'b0101);
        add_vec(OP_LSL, 32'h0000_0000, 32'h1234_5678, 1'b0, 32'h1234_5678, 4'b0101);
        add_vec(OP_SUB, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 4'b0110);
        add_vec(OP_ADC, 32'h0000_0005, 32'h0000_0007, 1'b0, 32'h0000_000D, 4'b0110);
        add_vec(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 32'hF000_F000, 4'b1010);
        add_vec(OP_ORR, 32'h0F00_0000, 32'h00F0_0000, 1'b1, 32'h0FF0_0000, 4'b0010);
        add_vec(OP_EOR, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b1, 32'h0000_0000, 4'b0110);
        add_vec(OP_LSL, 32'h0000_0001, 32'h8000_0001, 1'b1, 32'h0000_0002, 4'b0010);
        add_vec(OP_LSL, 32'h0000_0020, 32'h0000_0001, 1'b1, 32'h0000_0000, 4'b0110);
        add_vec(OP_ROR, 32'h0000_0024, 32'h0000_000F, 1'b1, 32'hF000_0000, 4'b1010);
        add_vec(OP_ROR, 32'h0000_0000, 32'h0000_0001, 1'b1, 32'h0000_0001, 4'b0010);
        add_vec(OP_ADC, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 32'h8000_0001, 4'b1001);

        for (int i = 0; i < vec_q.size(); i++) begin
            issue($sformatf("vec%0d", i), vec_q[i].op, vec_q[i].a, vec_q[i].b, vec_q[i].sf,
                  vec_q[i].res, vec_q[i].nzcv, 1'b1);
        end

        // Backpressure: first result held for 3 cycles, second op accepted when outReady rises
        @(posedge clk);
        #1;
        outReady = 1'b0;
        issue("bp_first", OP_AND, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b1, 32'h0F0F_0000, 4'b0001, 1'b1);
        fork
            issue("bp_second", OP_EOR, 32'h0000_0001, 32'h0000_0003, 1'b0, 32'h0000_0002, 4'b0001, 1'b1);
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk($sformatf("bp_hold_out%0d", i), aluOut, 32'h0F0F_0000);
                    chk($sformatf("bp_hold_inready%0d", i), {31'd0, inReady}, 32'd0);
                end
                @(posedge clk);
                #1;
                outReady = 1'b1;
            end
        join
        chk("bp_second_valid", {31'd0, outValid}, 32'd1);
        chk("bp_second_out", aluOut, 32'h0000_0002);

`ifdef ALU_MUL_EN
        issue("mul_big", OP_MUL, 32'h0001_0000, 32'h0001_0000, 1'b1, 32'h0000_0000, 4'b0101, 1'b1);
        k = 0;
        busy_cnt = busy ? 1 : 0;
        while (!outValid && k < 100) begin
            @(posedge clk);
            #1;
            k++;
            if (busy) busy_cnt++;
            if (k == 10) chk("mul_inready_low", {31'd0, inReady}, 32'd0);
        end
        chk("mul_latency", k, 33);
        chk("mul_busy_cycles", busy_cnt, 32);
        issue("mul_small", OP_MUL, 32'd7, 32'd6, 1'b1, 32'h0000_002A, 4'b0001, 1'b1);
        issue("mul_abort", OP_MUL, 32'd3, 32'd5, 1'b1, 32'd15, 4'b0000, 1'b0);
`else
        issue("mov", OP_MUL, 32'h0000_0000, 32'h0000_1234, 1'b1, 32'h0000_1234, 4'b0001, 1'b1);
        chk("mov_latency_valid", {31'd0, outValid}, 32'd1);
        chk("mov_latency_out", aluOut, 32'h0000_1234);
        issue("mov_pre_rst", OP_MUL, 32'h0000_0000, 32'h0000_0055, 1'b1, 32'h0000_0055, 4'b0001, 1'b1);
`endif

        // Reset 10 cycles into the last op
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_outvalid", {31'd0, outValid}, 32'd0);
        chk("abort_nzcv", {28'd0, N, Z, C, V}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("abort_inready", {31'd0, inReady}, 32'd1);
        repeat (40) @(posedge clk);
        #1;
        chk("abort_no_stale", {31'd0, outValid}, 32'd0);
        issue("adc_post_rst", OP_ADC, 32'd1, 32'd1, 1'b1, 32'd2, 4'b0000, 1'b1);

        repeat (5) @(posedge clk);
        #1;
        chk("sb_drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
